umi_endpoint_pipe: RTL and testbench
====================================

// Module: umi_endpoint_pipe
//
// PURPOSE
// - Next-generation UMI device endpoint with multiple outstanding requests and full response backpressure.
// - Converts UMI device requests into local memory read/write strobes.
// - Tracks up to DEPTH non-posted requests in flight.
// - Returns in-order read/write responses through a response FIFO.
// - Sits between a UMI device port and a fixed-latency local memory or register file.
//
// PARAMETERS
// - CW     32   UMI command width
// - AW     64   address width
// - DW     256  data width
// - DEPTH  4    max outstanding plus queued responses; power of 2, >=2
// - RDLAT  1    fixed loc_rddata latency in cycles after loc_read; >=1
//
// PORTS
// - clk                input   1        clock
// - reset              input   1        one clock; reset is synchronous and active-high
// - udev_req_valid     input   1        request valid
// - udev_req_cmd       input   CW       request command
// - udev_req_dstaddr   input   AW       request destination address
// - udev_req_srcaddr   input   AW       request source (return) address
// - udev_req_data      input   DW       request write data
// - udev_req_ready     output  1        request accepted when high with valid
// - udev_resp_valid    output  1        response valid (FIFO not empty)
// - udev_resp_cmd      output  CW       response command
// - udev_resp_dstaddr  output  AW       response destination = request srcaddr
// - udev_resp_srcaddr  output  AW       response source = request dstaddr
// - udev_resp_data     output  DW       read data (zero for write responses)
// - udev_resp_ready    input   1        response consumer ready
// - loc_addr           output  AW       = udev_req_dstaddr
// - loc_write          output  1        write strobe, one per accepted write/posted request
// - loc_read           output  1        read strobe, one per accepted read
// - loc_opcode         output  8        unpacked request opcode, zero-extended
// - loc_size           output  3        unpacked size
// - loc_len            output  8        unpacked len
// - loc_wrdata         output  DW       = udev_req_data
// - loc_rddata         input   DW       read data, valid exactly RDLAT cycles after loc_read
// - loc_ready          input   1        local device can accept an access this cycle
// - outstanding        output  $clog2(DEPTH)+1  responses in flight plus queued
//
// BEHAVIOUR
// - Request handshake and strobes
//   - fire = udev_req_valid & udev_req_ready.
//   - udev_req_ready = loc_ready & (outstanding < DEPTH); combinational, independent of cmd.
//   - loc_read = fire & read. loc_write = fire & (write | posted).
//   - Strobes are never asserted without fire.
// - Response generation
//   - Read and write requests allocate one credit: outstanding +1 on fire.
//   - Posted writes allocate no credit and generate no response.
//   - Pop is udev_resp_valid & udev_resp_ready; outstanding -1 on pop.
//   - Fire and pop in the same cycle leave outstanding unchanged.
//   - outstanding never exceeds DEPTH or wraps below 0.
// - Response pipeline
//   - Header {opcode, fields, addresses} enters an RDLAT-stage valid/header shift pipe on fire.
//   - Response opcode: UMI_RESP_READ for reads, UMI_RESP_WRITE for writes.
//   - size, len, atype, qos, prot, eom, eof, ex, user, hostid copied from request; err=2'b00.
//   - Write responses traverse the same pipe, so responses stay in request order.
//   - Pipe exit pushes {hdr, loc_rddata if read else 0} into a DEPTH-entry FIFO.
//   - The push never overflows because credits are reserved at fire.
//   - First response appears no earlier than RDLAT+1 cycles after fire.
//   - Full throughput: one request and one response per cycle while ready is held high.
// - Response output
//   - udev_resp_* are driven directly from the FIFO head and are stable while valid & !ready.
// - Unsupported commands (rdma, atomic, user, link, any response-type, invalid)
//   - Accepted under the same ready rule.
//   - No loc strobes.
//   - See CONFIGURATION for response behaviour.
// - Reset
//   - udev_resp_valid=0, outstanding=0, FIFO and pipe cleared, udev_resp_* fields =0.
//   - Reset mid-operation drops all in-flight and queued responses.
//   - loc_read/loc_write=0 during reset; udev_req_ready=0 during reset.
// - Pointers
//   - FIFO read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   - full/empty are decided by MSB compare.
//
// CONFIGURATION
// - UMI_ENDPOINT_ERRRESP_EN undefined
//   - Unsupported requests are dropped silently.
//   - No credit consumed, no response.
// - UMI_ENDPOINT_ERRRESP_EN defined
//   - Unsupported request-type commands other than posted consume a credit.
//   - They return an error response: opcode UMI_RESP_WRITE, err=2'b10, data=0, with normal RDLAT ordering.
//   - Response-type and invalid inbound commands are still dropped.
//
// TESTING
// - Read: mem[0x100]=0xA5; read dst=0x100 src=0x8000 len=0, RDLAT=1
//   -> one loc_read pulse; response RESP_READ, dstaddr=0x8000, srcaddr=0x100, data=0xA5, valid at cycle 2 after fire.
// - Write then read: write 0xDEAD to 0x40, then read 0x40
//   -> RESP_WRITE then RESP_READ data=0xDEAD, in that order.
// - Backpressure: udev_resp_ready=0, issue 6 reads with DEPTH=4
//   -> 4 accepted, udev_req_ready=0, outstanding=4, head stable.
//   -> Release ready: 4 in-order responses, then remaining 2 accepted.
// - Posted: 3 posted writes while outstanding=4 and full
//   -> stalled (ready=0). When not full: 3 loc_write pulses, no responses, outstanding unchanged.
// - Simultaneous: steady stream with udev_resp_ready=1
//   -> one fire and one pop per cycle, outstanding constant at RDLAT+1, no bubbles.
// - Reset and error: assert reset with 3 queued
//   -> next cycle valid=0, outstanding=0.
//   -> Atomic request with ERRRESP_EN gives err=2'b10, no loc strobes; without the macro, no response.

Source files
------------

// File: rtl/umi_endpoint_pipe_if.sv
// ---------------------------------------------------------------------------
// umi_endpoint_pipe_if
//   UMI device-port bundle carrying one request channel and one response
//   channel.
//
//   master : the host side. It drives requests and consumes responses.
//   slave  : the endpoint side. It accepts requests and produces responses.
//
//   Parameters: CW (command width), AW (address width), DW (data width).
// ---------------------------------------------------------------------------
interface umi_endpoint_pipe_if #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);
  // request channel
  logic          udev_req_valid;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr;
  logic [AW-1:0] udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_req_ready;
  // response channel
  logic          udev_resp_valid;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr;
  logic [AW-1:0] udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;
  logic          udev_resp_ready;

  modport master (
    output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
           udev_req_data, udev_resp_ready,
    input  udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
           udev_resp_srcaddr, udev_resp_data
  );

  modport slave (
    input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
           udev_req_data, udev_resp_ready,
    output udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
           udev_resp_srcaddr, udev_resp_data
  );
endinterface

// File: rtl/umi_endpoint_pipe.sv
// ---------------------------------------------------------------------------
// umi_endpoint_pipe
//   Pipelined UMI device endpoint. It turns UMI requests into single-cycle
//   local read and write strobes. It keeps up to DEPTH non-posted requests in
//   flight and returns their responses in request order through a
//   DEPTH-entry FIFO.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   udev           umi_endpoint_pipe_if.slave (request and response channels)
//   loc_addr       local address (= request dstaddr)
//   loc_write      write strobe (write and posted requests)
//   loc_read       read strobe
//   loc_opcode     request opcode, zero-extended to 8 bits
//   loc_size       request size field
//   loc_len        request len field
//   loc_wrdata     local write data (= request data)
//   loc_rddata     read data, valid RDLAT cycles after loc_read
//   loc_ready      the local device can take an access this cycle
//   outstanding    responses in flight plus responses queued
//
// Configuration
//   UMI_ENDPOINT_ERRRESP_EN  when defined, unsupported request-type commands
//                            (other than posted writes) return an error
//                            response. When undefined they are dropped.
// ---------------------------------------------------------------------------
module umi_endpoint_pipe #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int DEPTH = 4,
  parameter int RDLAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  umi_endpoint_pipe_if.slave       udev,
  output logic [AW-1:0]            loc_addr,
  output logic                     loc_write,
  output logic                     loc_read,
  output logic [7:0]               loc_opcode,
  output logic [2:0]               loc_size,
  output logic [7:0]               loc_len,
  output logic [DW-1:0]            loc_wrdata,
  input  logic [DW-1:0]            loc_rddata,
  input  logic                     loc_ready,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AI = $clog2(DEPTH);
  localparam int PW = AI + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic          is_read;
  } hdr_t;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
  } entry_t;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic [4:0] req_opcode;
  logic       is_read, is_write, is_posted, is_unsup_req;
  logic       needs_resp, err_resp;
  logic       fire, alloc, pop;
  logic [PW-1:0] cnt_q;

  assign req_opcode = udev.udev_req_cmd[4:0];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    is_read      = 1'b0;
    is_write     = 1'b0;
    is_posted    = 1'b0;
    is_unsup_req = 1'b0;
    case (req_opcode)
      UMI_REQ_READ:   is_read   = 1'b1;
      UMI_REQ_WRITE:  is_write  = 1'b1;
      UMI_REQ_POSTED: is_posted = 1'b1;
      // Request-type opcodes have bit 0 set. Even opcodes are responses or
      // invalid, and they are never answered.
      default:        is_unsup_req = req_opcode[0];
    endcase
  end

`ifdef UMI_ENDPOINT_ERRRESP_EN
  assign needs_resp = is_read | is_write | is_unsup_req;
  assign err_resp   = is_unsup_req;
`else
  assign needs_resp = is_read | is_write;
  assign err_resp   = 1'b0;
`endif

  // Ready depends only on credits and the local device, never on cmd. This
  // keeps the handshake free of combinational paths through the decode.
  assign udev.udev_req_ready = ~reset & loc_ready & (cnt_q < DEPTH_W);

  assign fire  = udev.udev_req_valid & udev.udev_req_ready;
  assign alloc = fire & needs_resp;
  assign pop   = udev.udev_resp_valid & udev.udev_resp_ready;

  assign loc_read   = fire & is_read;
  assign loc_write  = fire & (is_write | is_posted);
  assign loc_addr   = udev.udev_req_dstaddr;
  assign loc_wrdata = udev.udev_req_data;
  assign loc_opcode = {3'b000, req_opcode};
  assign loc_size   = udev.udev_req_cmd[7:5];
  assign loc_len    = udev.udev_req_cmd[15:8];

  // The response header swaps the addresses and replaces the opcode and err
  // field. Every other command field passes through unchanged.
  hdr_t new_hdr;
  always_comb begin
    new_hdr.cmd     = {udev.udev_req_cmd[CW-1:27],
                       (err_resp ? 2'b10 : 2'b00),
                       udev.udev_req_cmd[24:5],
                       (is_read ? UMI_RESP_READ : UMI_RESP_WRITE)};
    new_hdr.dstaddr = udev.udev_req_srcaddr;
    new_hdr.srcaddr = udev.udev_req_dstaddr;
    new_hdr.is_read = is_read;
  end

  // -------------------------------------------------------------------------
  // Credit counter: +1 on alloc and -1 on pop. If both happen in the same
  // cycle the count does not change.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      case ({alloc, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign outstanding = cnt_q;

  // -------------------------------------------------------------------------
  // Header pipe. It is RDLAT stages deep, so its exit lines up with
  // loc_rddata for reads. Writes and error responses travel through the same
  // stages, which keeps all responses in request order.
  // -------------------------------------------------------------------------
  logic [RDLAT-1:0] pipe_vld;
  hdr_t             pipe_hdr [RDLAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= alloc;
      for (int i = 1; i < RDLAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // NOTE: datapath storage (pipe headers, FIFO entries) is not reset. Only
  // the valid bits and pointers are reset, and they qualify every read of
  // that storage.
  always_ff @(posedge clk) begin
    pipe_hdr[0] <= new_hdr;
    for (int i = 1; i < RDLAT; i++) pipe_hdr[i] <= pipe_hdr[i-1];
  end

  // -------------------------------------------------------------------------
  // Response FIFO. The pointers carry one extra wrap bit. The FIFO is empty
  // when the pointers are equal and full when only the MSBs differ.
  // -------------------------------------------------------------------------
  entry_t        fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push;
  entry_t        push_entry, head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AI-1:0] == rd_ptr[AI-1:0]);

  // Credits are reserved at fire, so a push never meets a full FIFO. The
  // full term only protects against a corrupted pointer.
  assign push = pipe_vld[RDLAT-1] & ~fifo_full;

  always_comb begin
    push_entry.cmd     = pipe_hdr[RDLAT-1].cmd;
    push_entry.dstaddr = pipe_hdr[RDLAT-1].dstaddr;
    push_entry.srcaddr = pipe_hdr[RDLAT-1].srcaddr;
    push_entry.data    = pipe_hdr[RDLAT-1].is_read ? loc_rddata : '0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AI-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The outputs come straight from the FIFO head, so they stay stable while
  // valid is high and ready is low. They read as zero whenever the FIFO is
  // empty, which includes the cycles just after reset.
  assign head                   = fifo_mem[rd_ptr[AI-1:0]];
  assign udev.udev_resp_valid   = ~fifo_empty;
  assign udev.udev_resp_cmd     = fifo_empty ? '0 : head.cmd;
  assign udev.udev_resp_dstaddr = fifo_empty ? '0 : head.dstaddr;
  assign udev.udev_resp_srcaddr = fifo_empty ? '0 : head.srcaddr;
  assign udev.udev_resp_data    = fifo_empty ? '0 : head.data;

endmodule

// File: tb/tb_umi_endpoint_pipe.sv
// ---------------------------------------------------------------------------
// tb_umi_endpoint_pipe
//   Directed bench for umi_endpoint_pipe (DEPTH=4, RDLAT=1). Expected
//   responses are queued when a request fires and are compared when the DUT
//   pops them. Local memory is a behavioural model with one-cycle read
//   latency.
// ---------------------------------------------------------------------------
module tb_umi_endpoint_pipe;

  localparam int CW = 32, AW = 64, DW = 256, DEPTH = 4, RDLAT = 1;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] REQ_ATOMIC = 5'h09;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] loc_addr;
  logic          loc_write, loc_read, loc_ready;
  logic [7:0]    loc_opcode, loc_len;
  logic [2:0]    loc_size;
  logic [DW-1:0] loc_wrdata, loc_rddata;
  logic [$clog2(DEPTH):0] outstanding;

  umi_endpoint_pipe_if #(.CW(CW), .AW(AW), .DW(DW)) udev ();

  umi_endpoint_pipe #(.CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH), .RDLAT(RDLAT)) dut (
    .clk(clk), .reset(reset), .udev(udev),
    .loc_addr(loc_addr), .loc_write(loc_write), .loc_read(loc_read),
    .loc_opcode(loc_opcode), .loc_size(loc_size), .loc_len(loc_len),
    .loc_wrdata(loc_wrdata), .loc_rddata(loc_rddata), .loc_ready(loc_ready),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0, wr_cnt = 0, n_resp = 0, cyc = 0;
  logic [31:0] cur_cmd;
  resp_t sb [$];
  logic [DW-1:0] lmem    [logic [AW-1:0]];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Local memory model with one-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (loc_write) begin lmem[loc_addr] = loc_wrdata; wr_cnt++; end
    if (loc_read) rd_cnt++;
    loc_rddata <= (loc_read && lmem.exists(loc_addr)) ? lmem[loc_addr] : '0;
  end

  // Scoreboard monitor: a pop happens at the next edge.
  always @(negedge clk) begin
    if (!reset && udev.udev_resp_valid && udev.udev_resp_ready) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 256'(udev.udev_resp_valid), 256'(0));
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("resp_cmd",  256'(udev.udev_resp_cmd),     256'(e.cmd));
        check("resp_dst",  256'(udev.udev_resp_dstaddr), 256'(e.dst));
        check("resp_src",  256'(udev.udev_resp_srcaddr), 256'(e.src));
        check("resp_data", 256'(udev.udev_resp_data),    256'(e.data));
        n_resp++;
      end
    end
  end

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : '0;
  endfunction

  function automatic resp_t mk_exp(input logic [31:0] rc, input logic [4:0] opc,
                                   input logic [1:0] err, input logic [AW-1:0] rdst,
                                   input logic [AW-1:0] rsrc, input logic [DW-1:0] d);
    resp_t r;
    r.cmd  = {rc[31:27], err, rc[24:5], opc};
    r.dst  = rsrc;
    r.src  = rdst;
    r.data = d;
    return r;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // cmd = {hostid, user, ex, eof, eom, prot, qos, len, size, opcode}
  task automatic set_req(input logic [4:0] opc, input logic [AW-1:0] dst,
                         input logic [AW-1:0] src, input logic [DW-1:0] wdata,
                         input logic [7:0] len);
    cur_cmd = {5'h05, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 4'h3, len, 3'h2, opc};
    udev.udev_req_valid   = 1'b1;
    udev.udev_req_cmd     = cur_cmd;
    udev.udev_req_dstaddr = dst;
    udev.udev_req_srcaddr = src;
    udev.udev_req_data    = wdata;
  endtask

  // Waits (bounded) for the pending request to fire. The expected response
  // is queued on the fire cycle.
  task automatic wait_fire(input string tag, input bit push, input resp_t e);
    int n = 0;
    forever begin
      @(negedge clk);
      if (udev.udev_req_ready) break;
      n++;
      if (n > 100) begin
        check({tag, "_fire_timeout"}, 256'(0), 256'(1));
        udev.udev_req_valid = 1'b0;
        return;
      end
    end
    if (push) sb.push_back(e);
    tick();
    udev.udev_req_valid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] dst, input logic [AW-1:0] src);
    set_req(REQ_READ, dst, src, '0, 8'h00);
    wait_fire(tag, 1'b1, mk_exp(cur_cmd, RESP_READ, 2'b00, dst, src, mem_val(dst)));
  endtask

  initial begin
    int rd0, wr0, nr0, c0;
    resp_t e;
    for (int i = 0; i < 8; i++) begin
      lmem[64'h200 + 64'(i*8)]    = 256'h1000 + 256'(i*17);
      exp_mem[64'h200 + 64'(i*8)] = 256'h1000 + 256'(i*17);
    end
    lmem[64'h100] = 256'hA5;  exp_mem[64'h100] = 256'hA5;

    // ---- reset (a valid request is held during reset and must not fire) ---
    reset = 1'b1; loc_ready = 1'b1; udev.udev_resp_ready = 1'b0;
    set_req(REQ_READ, 64'h100, 64'h1, '0, 8'h00);
    @(negedge clk);
    check("rst_req_ready", 256'(udev.udev_req_ready), 256'(0));
    check("rst_loc_read",  256'(loc_read), 256'(0));
    tick(2);
    udev.udev_req_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("rst_resp_valid",  256'(udev.udev_resp_valid), 256'(0));
    check("rst_outstanding", 256'(outstanding), 256'(0));
    check("rst_resp_cmd",    256'(udev.udev_resp_cmd), 256'(0));
    check("rst_rd_cnt",      256'(rd_cnt), 256'(0));

    // ---- single read with response latency ----
    rd0 = rd_cnt;
    do_read("rd", 64'h100, 64'h8000);
    check("rd_not_yet_valid", 256'(udev.udev_resp_valid), 256'(0));
    check("rd_outstanding",   256'(outstanding), 256'(1));
    tick();
    check("rd_valid_cycle2", 256'(udev.udev_resp_valid), 256'(1));
    check("rd_strobes",      256'(rd_cnt - rd0), 256'(1));
    udev.udev_resp_ready = 1'b1;
    tick(2);
    check("rd_drained", 256'(sb.size()), 256'(0));
    check("rd_out0",    256'(outstanding), 256'(0));

    // ---- write then read ----
    nr0 = n_resp;
    set_req(REQ_WRITE, 64'h40, 64'h9000, 256'hDEAD, 8'h00);
    exp_mem[64'h40] = 256'hDEAD;
    wait_fire("wr", 1'b1, mk_exp(cur_cmd, RESP_WRITE, 2'b00, 64'h40, 64'h9000, '0));
    do_read("wr_rd", 64'h40, 64'h9000);
    tick(4);
    check("wr_rd_count", 256'(n_resp - nr0), 256'(2));
    check("wr_rd_empty", 256'(sb.size()), 256'(0));

    // ---- backpressure: 6 reads, only 4 fit ----
    udev.udev_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_read("bp", 64'h200 + 64'(i*8), 64'hA000 + 64'(i));
    set_req(REQ_READ, 64'h220, 64'hA004, '0, 8'h00);
    tick(3);
    check("bp_ready_low",  256'(udev.udev_req_ready), 256'(0));
    check("bp_out4",       256'(outstanding), 256'(4));
    check("bp_head_dst",   256'(udev.udev_resp_dstaddr), 256'(64'hA000));
    check("bp_head_data",  256'(udev.udev_resp_data), 256'(mem_val(64'h200)));
    tick(2);
    check("bp_head_stable", 256'(udev.udev_resp_data), 256'(mem_val(64'h200)));
    udev.udev_resp_ready = 1'b1;
    wait_fire("bp5", 1'b1, mk_exp(cur_cmd, RESP_READ, 2'b00, 64'h220, 64'hA004, mem_val(64'h220)));
    do_read("bp6", 64'h228, 64'hA005);
    tick(6);
    check("bp_empty", 256'(sb.size()), 256'(0));
    check("bp_out0",  256'(outstanding), 256'(0));

    // ---- posted writes stall while full, then issue without responses ----
    udev.udev_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_read("pw_fill", 64'h200 + 64'(i*8), 64'hD000 + 64'(i));
    wr0 = wr_cnt; nr0 = n_resp;
    set_req(REQ_POSTED, 64'h300, 64'h0, 256'h11, 8'h00);
    tick(2);
    check("pw_stall_ready", 256'(udev.udev_req_ready), 256'(0));
    check("pw_stall_write", 256'(wr_cnt - wr0), 256'(0));
    udev.udev_resp_ready = 1'b1;
    exp_mem[64'h300] = 256'h11;
    wait_fire("pw0", 1'b0, e);
    for (int i = 1; i < 3; i++) begin
      set_req(REQ_POSTED, 64'h300 + 64'(i*8), 64'h0, 256'h11 + 256'(i), 8'h00);
      exp_mem[64'h300 + 64'(i*8)] = 256'h11 + 256'(i);
      wait_fire("pw", 1'b0, e);
    end
    tick(6);
    check("pw_writes", 256'(wr_cnt - wr0), 256'(3));
    check("pw_resps",  256'(n_resp - nr0), 256'(4));
    check("pw_out0",   256'(outstanding), 256'(0));
    do_read("pw_readback", 64'h308, 64'hD100);
    tick(3);

    // ---- streaming: one fire and one pop per cycle ----
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      do_read("st", 64'h200 + 64'((i % 4) * 8), 64'hB000 + 64'(i));
      if (i >= 1) begin
        check("st_out_const", 256'(outstanding), 256'(RDLAT + 1));
        check("st_valid",     256'(udev.udev_resp_valid), 256'(1));
      end
    end
    check("st_no_bubble", 256'(cyc - c0), 256'(10));
    tick(4);
    check("st_empty", 256'(sb.size()), 256'(0));

    // ---- reset with 3 queued responses ----
    udev.udev_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_read("rq", 64'h200, 64'hE000 + 64'(i));
    tick(3);
    check("rq_out3", 256'(outstanding), 256'(3));
    reset = 1'b1;
    sb.delete();
    tick();
    check("rq_rst_ready", 256'(udev.udev_req_ready), 256'(0));
    check("rq_rst_valid", 256'(udev.udev_resp_valid), 256'(0));
    check("rq_rst_out",   256'(outstanding), 256'(0));
    reset = 1'b0;
    udev.udev_resp_ready = 1'b1;
    tick(3);
    check("rq_after_valid", 256'(udev.udev_resp_valid), 256'(0));

    // ---- response-type inbound command is dropped ----
    nr0 = n_resp;
    set_req(RESP_READ, 64'h100, 64'hF000, '0, 8'h00);
    wait_fire("drop", 1'b0, e);
    tick(4);
    check("drop_out0",  256'(outstanding), 256'(0));
    check("drop_nresp", 256'(n_resp - nr0), 256'(0));

    // ---- atomic: no strobes; error response only with the macro ----
    rd0 = rd_cnt; wr0 = wr_cnt; nr0 = n_resp;
    set_req(REQ_ATOMIC, 64'h400, 64'hC000, 256'h77, 8'h00);
`ifdef UMI_ENDPOINT_ERRRESP_EN
    wait_fire("atomic", 1'b1, mk_exp(cur_cmd, RESP_WRITE, 2'b10, 64'h400, 64'hC000, '0));
    tick(4);
    check("atomic_nresp", 256'(n_resp - nr0), 256'(1));
`else
    wait_fire("atomic", 1'b0, e);
    tick(4);
    check("atomic_nresp", 256'(n_resp - nr0), 256'(0));
`endif
    check("atomic_no_rd", 256'(rd_cnt - rd0), 256'(0));
    check("atomic_no_wr", 256'(wr_cnt - wr0), 256'(0));
    check("atomic_out0",  256'(outstanding), 256'(0));

    // ---- loc_ready low blocks acceptance ----
    loc_ready = 1'b0;
    set_req(REQ_READ, 64'h208, 64'hC100, '0, 8'h00);
    @(negedge clk);
    check("locrdy_block", 256'(udev.udev_req_ready), 256'(0));
    tick();
    loc_ready = 1'b1;
    wait_fire("locrdy", 1'b1, mk_exp(cur_cmd, RESP_READ, 2'b00, 64'h208, 64'hC100, mem_val(64'h208)));
    tick(4);

    check("final_sb_empty", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
